i2c_domain_target: RTL and testbench
====================================

// Module: i2c_domain_target
// PURPOSE
//  I2C target (responder) for the domain-isolated I2C subsystem. It is the bus-side
//  counterpart to the Wishbone I2C master sequencer: it decodes START/STOP, matches a
//  7-bit address, and serves reads/writes to an internal NREGS x 8 register bank.
//  It responds only while the bus domain tag equals its own DOMAIN. Otherwise the bus
//  stays released, so no data crosses domains.
// PARAMETERS
//  ADDR     7'h10  7-bit I2C target address
//  DOMAIN   1'b0   security domain served (0-D1, 1-D2)
//  NREGS    4      register bank depth (power of 2, 2..16)
//  RST_VAL  8'h00  reset value of every bank entry
// PORTS
//  clk         in   1          system clock, >= 8x SCL rate
//  rst         in   1          async reset, active-high
//  domain_i2c  in   1          current bus domain tag from the world controller
//  scl_i       in   1          SCL pad input (asynchronous)
//  sda_i       in   1          SDA pad input (asynchronous)
//  sda_oe      out  1          1 = pull SDA low; 0 = release (open-drain)
//  wr_strobe   out  1          1-cycle pulse when a bank entry is written via I2C
//  wr_addr     out  log2(NREGS) index written (valid with wr_strobe)
//  wr_data     out  8          data written (valid with wr_strobe)
//  busy        out  1          1 from address-match ACK until STOP or return to IDLE
// BEHAVIOUR
//  - Reset values: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE,
//    pointer=0, all bank entries=RST_VAL. Reset mid-transfer releases SDA within 0 cycles (async).
//  - Input sync: scl_i/sda_i pass through 2-flop synchronisers; edges are taken from the
//    synced value vs a 1-cycle delayed copy. START = SDA fall while SCL high; STOP = SDA rise
//    while SCL high. START has priority and is honoured in every state (repeated START -> ADDR).
//  - STOP in any state -> IDLE, sda_oe=0, busy=0 on the next clk.
//  - Bits are sampled on the SCL rising edge, MSB first. sda_oe changes only on the clk after
//    an SCL falling edge.
//  - States:
//    IDLE: wait for START -> ADDR.
//    ADDR: shift 8 bits. Match when [7:1]==ADDR and domain_i2c==DOMAIN -> A_ACK.
//      Mismatch -> WAIT_STOP (never ACK).
//    A_ACK: drive ACK for one SCL period; busy=1. R/W=0 -> PTR; R/W=1 -> RDATA
//      (preload shift reg with bank[pointer]).
//    PTR: shift 8 bits; pointer = byte mod NREGS -> P_ACK (ACK) -> WDATA.
//    WDATA: shift 8 bits -> D_ACK. On the SCL fall ending the 8th bit: bank[pointer]=byte,
//      wr_strobe pulses 1 clk, and wr_addr/wr_data are updated. pointer++ with wrap to 0.
//      After ACK -> WDATA.
//    RDATA: drive ~bit (sda_oe=1 for a 0 bit) after each SCL fall, 8 bits.
//      Then release -> M_ACK.
//    M_ACK: sample SDA on SCL rise. ACK(0): pointer++ wrap, preload next byte -> RDATA.
//      NACK(1) -> WAIT_STOP.
//    WAIT_STOP: SDA released; exit only on START/STOP.
//  - Read pointer increments only on a master ACK. Write pointer increments after each
//    stored byte. Pointer persists across transactions until reset.
//  - domain_i2c changing mid-transaction: abort to WAIT_STOP and release SDA next clk.
//  - In RDATA, a START/STOP seen while driving is still decoded (the master wins arbitration).
// TESTING
//  1 Reset -> sda_oe=0, busy=0. Write 0x20 (addr 0x10,W), ptr 0x01, data 0xA5
//    -> ACKs on 3 bytes; wr_strobe with wr_addr=1, wr_data=0xA5.
//  2 Ptr 0x03, data 0x11,0x22 -> bank[3]=0x11, bank[0]=0x22 (wrap); two wr_strobe pulses.
//  3 Write ptr 0x01, repeated START, read 0x21 with 2 bytes ACK,NACK -> SDA returns 0xA5,
//    then bank[2]=0x00; idle after STOP.
//  4 Address 0x22 (target 0x10) -> no ACK, sda_oe stays 0, busy=0, bank unchanged.
//  5 domain_i2c=1 with DOMAIN=0, address 0x20 -> no ACK. Flip domain mid-write
//    -> SDA released next clk, no wr_strobe.
//  6 Assert rst while driving a 0 read bit -> sda_oe=0 immediately; bank=RST_VAL.

Source files
------------

// File: rtl/i2c_domain_target_if.sv
// i2c_domain_target_if: pad, domain and write-notify signals between an I2C target and its environment.
interface i2c_domain_target_if #(parameter int NREGS = 4);
    localparam int AW = $clog2(NREGS);
    logic          domain_i2c;
    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    modport master (output domain_i2c, scl_i, sda_i, input sda_oe, wr_strobe, wr_addr, wr_data, busy);
    modport slave  (input domain_i2c, scl_i, sda_i, output sda_oe, wr_strobe, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_domain_target.sv
// i2c_domain_target: domain-gated I2C target serving an NREGS x 8 register bank.
module i2c_domain_target #(
    parameter logic [6:0] ADDR    = 7'h10,
    parameter logic       DOMAIN  = 1'b0,
    parameter int         NREGS   = 4,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input logic             clk,
    input logic             rst,
    i2c_domain_target_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK, S_WDATA, S_D_ACK, S_RDATA, S_M_ACK, S_WAIT
    } state_t;
    state_t        state, state_n;
    logic [1:0]    scl_s, sda_s;
    logic          scl_d, sda_d, scl, sda, rise, fall, start, stop, active, abort;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic [AW-1:0] ptr, ptr_n, wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    bank [NREGS];
    logic          oe, oe_n, busy, busy_n, we, wr_strobe;
    assign scl    = scl_s[1];
    assign sda    = sda_s[1];
    assign rise   = scl & ~scl_d;
    assign fall   = ~scl & scl_d;
    assign start  = scl & scl_d & sda_d & ~sda;
    assign stop   = scl & scl_d & ~sda_d & sda;
    assign active = state inside {S_A_ACK, S_PTR, S_P_ACK, S_WDATA, S_D_ACK, S_RDATA, S_M_ACK};
    assign abort  = active && (bus.domain_i2c != DOMAIN);
    assign bus.sda_oe    = oe;
    assign bus.busy      = busy;
    assign bus.wr_strobe = wr_strobe;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        oe_n    = oe;
        busy_n  = busy;
        we      = 1'b0;
        if (start) begin
            state_n = S_ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end else if (stop) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (abort) begin
            state_n = S_WAIT;
            oe_n    = 1'b0;
        end else if (rise) begin
            if (state inside {S_ADDR, S_PTR, S_WDATA}) begin
                sh_n  = {sh[6:0], sda};
                cnt_n = cnt + 4'd1;
            end else if (state == S_RDATA) begin
                cnt_n = cnt + 4'd1;
            end else if (state == S_M_ACK) begin
                state_n = sda ? S_WAIT : state;
                ptr_n   = sda ? ptr : ptr + 1'b1;
            end
        end else if (fall) begin
            case (state)
                S_ADDR: if (cnt == 4'd8) begin
                    // an ACK is only ever driven for our own address in our own domain
                    if (sh[7:1] == ADDR && bus.domain_i2c == DOMAIN) begin
                        state_n = S_A_ACK;
                        oe_n    = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_A_ACK: begin
                    cnt_n   = 4'd0;
                    state_n = sh[0] ? S_RDATA : S_PTR;
                    sh_n    = sh[0] ? bank[ptr] : sh;
                    oe_n    = sh[0] ? ~bank[ptr][7] : 1'b0;
                end
                S_PTR: if (cnt == 4'd8) begin
                    ptr_n   = sh[AW-1:0];
                    state_n = S_P_ACK;
                    oe_n    = 1'b1;
                end
                S_P_ACK, S_D_ACK: begin
                    state_n = S_WDATA;
                    cnt_n   = 4'd0;
                    oe_n    = 1'b0;
                end
                S_WDATA: if (cnt == 4'd8) begin
                    we      = 1'b1;
                    ptr_n   = ptr + 1'b1;
                    state_n = S_D_ACK;
                    oe_n    = 1'b1;
                end
                S_RDATA: begin
                    state_n = (cnt == 4'd8) ? S_M_ACK : state;
                    sh_n    = {sh[6:0], 1'b0};
                    oe_n    = (cnt == 4'd8) ? 1'b0 : ~sh[6];
                end
                S_M_ACK: begin
                    state_n = S_RDATA;
                    cnt_n   = 4'd0;
                    sh_n    = bank[ptr];
                    oe_n    = ~bank[ptr][7];
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            scl_s     <= 2'b11;
            sda_s     <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            cnt       <= 4'd0;
            sh        <= 8'd0;
            ptr       <= '0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
            for (int i = 0; i < NREGS; i++) bank[i] <= RST_VAL;
        end else begin
            scl_s     <= {scl_s[0], bus.scl_i};
            sda_s     <= {sda_s[0], bus.sda_i};
            scl_d     <= scl;
            sda_d     <= sda;
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            oe        <= oe_n;
            busy      <= busy_n;
            wr_strobe <= we;
            if (we) begin
                bank[ptr] <= sh;
                wr_addr   <= ptr;
                wr_data   <= sh;
            end
        end
    end
endmodule

// File: tb/tb_i2c_domain_target.sv
// tb_i2c_domain_target: directed I2C master sequences against the domain-gated target.
module tb_i2c_domain_target;
    localparam int Q = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   stb_cnt = 0;
    int   oe_cnt = 0;
    logic [1:0] stb_addr [16];
    logic [7:0] stb_data [16];
    i2c_domain_target_if #(.NREGS(4)) bus ();
    i2c_domain_target #(.ADDR(7'h10), .DOMAIN(1'b0), .NREGS(4), .RST_VAL(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
        if (bus.wr_strobe) begin
            stb_addr[stb_cnt[3:0]] <= bus.wr_addr;
            stb_data[stb_cnt[3:0]] <= bus.wr_data;
            stb_cnt <= stb_cnt + 1;
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1);
    end
    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask
    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask
    task automatic bit_cycle(input logic b, output logic r);
        sda_m = b;    wq(Q);
        scl_m = 1'b1; wq(Q);
        r = bus.sda_i; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask
    task automatic byte_wr(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], r);
        bit_cycle(1'b1, r);
        ack = ~r;
    endtask
    task automatic byte_rd(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, r);
            d[i] = r;
        end
        bit_cycle(mack, r);
    endtask
    initial begin
        logic       ack;
        logic [7:0] d;
        int         s0, o0;
        bus.domain_i2c = 1'b0;
        wq(3);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_strobe", bus.wr_strobe, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        rst = 1'b0;
        wq(Q);
        // write 0xA5 to index 1
        i2c_start();
        byte_wr(8'h20, ack); chk("t1_addr_ack", ack, 1);
        chk("t1_busy", bus.busy, 1);
        byte_wr(8'h01, ack); chk("t1_ptr_ack", ack, 1);
        byte_wr(8'hA5, ack); chk("t1_data_ack", ack, 1);
        i2c_stop();
        wq(Q);
        chk("t1_busy_after_stop", bus.busy, 0);
        chk("t1_strobes", stb_cnt, 1);
        chk("t1_wr_addr", stb_addr[0], 1);
        chk("t1_wr_data", stb_data[0], 8'hA5);
        // pointer wraps from 3 to 0
        i2c_start();
        byte_wr(8'h20, ack); chk("t2_addr_ack", ack, 1);
        byte_wr(8'h03, ack); chk("t2_ptr_ack", ack, 1);
        byte_wr(8'h11, ack); chk("t2_d0_ack", ack, 1);
        byte_wr(8'h22, ack); chk("t2_d1_ack", ack, 1);
        i2c_stop();
        wq(Q);
        chk("t2_strobes", stb_cnt, 3);
        chk("t2_wr_addr0", stb_addr[1], 3);
        chk("t2_wr_data0", stb_data[1], 8'h11);
        chk("t2_wr_addr1", stb_addr[2], 0);
        chk("t2_wr_data1", stb_data[2], 8'h22);
        // pointer write, repeated START, read two bytes
        i2c_start();
        byte_wr(8'h20, ack); chk("t3_addr_ack", ack, 1);
        byte_wr(8'h01, ack); chk("t3_ptr_ack", ack, 1);
        i2c_start();
        byte_wr(8'h21, ack); chk("t3_raddr_ack", ack, 1);
        byte_rd(1'b0, d); chk("t3_rd0", d, 8'hA5);
        byte_rd(1'b1, d); chk("t3_rd1", d, 8'h00);
        i2c_stop();
        wq(Q);
        chk("t3_busy_idle", bus.busy, 0);
        chk("t3_sda_oe_idle", bus.sda_oe, 0);
        chk("t3_strobes", stb_cnt, 3);
        // foreign address
        o0 = oe_cnt;
        i2c_start();
        byte_wr(8'h22, ack); chk("t4_no_ack", ack, 0);
        byte_wr(8'h5A, ack); chk("t4_no_data_ack", ack, 0);
        chk("t4_busy", bus.busy, 0);
        i2c_stop();
        wq(Q);
        chk("t4_oe_never", oe_cnt - o0, 0);
        chk("t4_strobes", stb_cnt, 3);
        // foreign domain at address phase
        bus.domain_i2c = 1'b1;
        i2c_start();
        byte_wr(8'h20, ack); chk("t5_dom_no_ack", ack, 0);
        i2c_stop();
        wq(Q);
        chk("t5_oe_never", oe_cnt - o0, 0);
        chk("t5_busy", bus.busy, 0);
        // domain flips while the pointer ACK is being driven
        bus.domain_i2c = 1'b0;
        s0 = stb_cnt;
        i2c_start();
        byte_wr(8'h20, ack); chk("t5_addr_ack", ack, 1);
        for (int i = 7; i >= 0; i--) bit_cycle(i == 1, ack);
        sda_m = 1'b1;
        wq(Q);
        chk("t5_ptr_ack_driven", bus.sda_oe, 1);
        bus.domain_i2c = 1'b1;
        wq(1);
        chk("t5_released_next_clk", bus.sda_oe, 0);
        scl_m = 1'b1; wq(2 * Q);
        scl_m = 1'b0; wq(Q);
        byte_wr(8'h77, ack); chk("t5_data_no_ack", ack, 0);
        i2c_stop();
        wq(Q);
        chk("t5_no_strobe", stb_cnt - s0, 0);
        bus.domain_i2c = 1'b0;
        wq(Q);
        // reset while a 0 read bit is driven
        i2c_start();
        byte_wr(8'h20, ack); chk("t6_addr_ack", ack, 1);
        byte_wr(8'h03, ack); chk("t6_ptr_ack", ack, 1);
        i2c_start();
        byte_wr(8'h21, ack); chk("t6_raddr_ack", ack, 1);
        byte_rd(1'b0, d); chk("t6_rd3", d, 8'h11);
        chk("t6_driving_zero", bus.sda_oe, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_release", bus.sda_oe, 0);
        chk("t6_busy_rst", bus.busy, 0);
        wq(2);
        rst = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1;
        wq(Q);
        i2c_start();
        byte_wr(8'h21, ack); chk("t6_read_ack", ack, 1);
        for (int i = 0; i < 4; i++) begin
            byte_rd(i == 3, d);
            chk($sformatf("t6_bank%0d_rst", i), d, 8'h00);
        end
        i2c_stop();
        wq(Q);
        chk("t6_wr_addr_rst", bus.wr_addr, 0);
        chk("t6_wr_data_rst", bus.wr_data, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
